// File: rtl/mem_access_ctrl.sv
// Load/store sequencer between the execute stage and a word-only data memory.
// Sub-word loads extract and extend a lane. Sub-word stores do a read-modify-write.
// Misaligned requests complete with an error and never reach the memory.
module mem_access_ctrl (
  input  logic        Clk,
  input  logic        Clr,
  input  logic        Req,
  output logic        Ready,
  input  logic [2:0]  Op,
  input  logic [31:0] Addr,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        Done,
  output logic        Err,
  output logic [31:0] MemAddr,
  output logic [31:0] MemDin,
  output logic        MemWe,
  input  logic [31:0] MemDout
);

  localparam logic [2:0] OpLw  = 3'b000;
  localparam logic [2:0] OpLh  = 3'b001;
  localparam logic [2:0] OpLhu = 3'b010;
  localparam logic [2:0] OpLb  = 3'b011;
  localparam logic [2:0] OpLbu = 3'b100;
  localparam logic [2:0] OpSw  = 3'b101;
  localparam logic [2:0] OpSh  = 3'b110;
  localparam logic [2:0] OpSb  = 3'b111;

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [31:0] addr_q, wdata_q, word_q, rdata_q;
  logic        err_q;
  logic        misaligned;
  logic [31:0] store_word;

  // Extract the addressed lane of a memory word and extend it for the given load op.
  function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic [15:0] half;
    logic [7:0]  byte_v;
    half = lo[1] ? w[31:16] : w[15:0];
    unique case (lo)
      2'd0:    byte_v = w[7:0];
      2'd1:    byte_v = w[15:8];
      2'd2:    byte_v = w[23:16];
      default: byte_v = w[31:24];
    endcase
    unique case (op)
      OpLh:    load_ext = {{16{half[15]}}, half};
      OpLhu:   load_ext = {16'h0000, half};
      OpLb:    load_ext = {{24{byte_v[7]}}, byte_v};
      OpLbu:   load_ext = {24'h000000, byte_v};
      default: load_ext = w;
    endcase
  endfunction

  // Alignment check on the incoming request: words need [1:0]==0, halves need [0]==0.
  always_comb begin
    misaligned = 1'b0;
    if ((Op == OpLw || Op == OpSw) && Addr[1:0] != 2'b00) misaligned = 1'b1;
    if ((Op == OpLh || Op == OpLhu || Op == OpSh) && Addr[0]) misaligned = 1'b1;
  end

  // State register; Clr abandons any access in flight.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          if (misaligned)      state_d = StResp;
          else if (Op == OpSw) state_d = StWrite;
          else                 state_d = StRead;
        end
      end
      StRead:  state_d = (op_q <= OpLbu) ? StResp : StWrite;
      StWrite: state_d = StResp;
      default: state_d = StIdle;
    endcase
  end

  // Request latch, read capture and load result register.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      op_q    <= OpLw;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (state_q == StIdle && Req) begin
        op_q    <= Op;
        addr_q  <= Addr;
        wdata_q <= Wdata;
        err_q   <= misaligned;
      end
      if (state_q == StRead) begin
        word_q <= MemDout;
        // Loads go straight to RESP, so the result must be visible there.
        if (op_q <= OpLbu) rdata_q <= load_ext(op_q, addr_q[1:0], MemDout);
      end
    end
  end

  // Store data: full word for sw, otherwise the captured word with one lane replaced.
  always_comb begin
    store_word = word_q;
    if (op_q == OpSw) begin
      store_word = wdata_q;
    end else if (op_q == OpSh) begin
      if (addr_q[1]) store_word[31:16] = wdata_q[15:0];
      else           store_word[15:0]  = wdata_q[15:0];
    end else if (op_q == OpSb) begin
      unique case (addr_q[1:0])
        2'd0:    store_word[7:0]   = wdata_q[7:0];
        2'd1:    store_word[15:8]  = wdata_q[7:0];
        2'd2:    store_word[23:16] = wdata_q[7:0];
        default: store_word[31:24] = wdata_q[7:0];
      endcase
    end
  end

  // Output decode; MemWe follows state combinationally so Clr kills a pending write.
  always_comb begin
    Ready   = (state_q == StIdle);
    Done    = (state_q == StResp);
    Err     = (state_q == StResp) && err_q;
    MemWe   = (state_q == StWrite);
    MemAddr = {addr_q[31:2], 2'b00};
    MemDin  = (state_q == StWrite) ? store_word : '0;
    Rdata   = rdata_q;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl with a small word memory model behind it.
module tb_mem_access_ctrl;

  logic        Clk, Clr, Req, Ready, Done, Err, MemWe;
  logic [2:0]  Op;
  logic [31:0] Addr, Wdata, Rdata, MemAddr, MemDin, MemDout;

  logic [31:0] mem [32];
  int          we_tot;
  logic [31:0] last_din;
  int          n_cmp, n_bad;
  logic [32:0] exp_q [$];
  logic [31:0] rdata_model;

  mem_access_ctrl dut (
    .Clk(Clk), .Clr(Clr), .Req(Req), .Ready(Ready), .Op(Op), .Addr(Addr), .Wdata(Wdata),
    .Rdata(Rdata), .Done(Done), .Err(Err), .MemAddr(MemAddr), .MemDin(MemDin),
    .MemWe(MemWe), .MemDout(MemDout)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Data memory: combinational read, synchronous write.
  assign MemDout = mem[MemAddr[6:2]];
  always @(posedge Clk) begin
    if (MemWe) begin
      mem[MemAddr[6:2]] <= MemDin;
      we_tot   = we_tot + 1;
      last_din = MemDin;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Issue one request, wait for Done and check result, error, latency and write count.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rdata, input int exp_we);
    int lat, we0;
    bit seen;
    logic [32:0] e;
    exp_q.push_back({exp_err, exp_rdata});
    @(negedge Clk);
    check_eq({tag, "_ready"}, 32'(Ready), 32'd1);
    we0 = we_tot;
    Req = 1'b1; Op = op; Addr = addr; Wdata = wdata;
    @(posedge Clk);
    lat = 1;
    @(negedge Clk);
    Req = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 8) begin
      if (Done) seen = 1'b1;
      else begin
        @(posedge Clk);
        lat++;
        @(negedge Clk);
      end
    end
    if (!seen) begin
      check_eq({tag, "_done_timeout"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      check_eq({tag, "_err"}, 32'(Err), 32'(e[32]));
      check_eq({tag, "_rdata"}, Rdata, e[31:0]);
      check_eq({tag, "_we_cnt"}, 32'(we_tot - we0), 32'(exp_we));
    end
  endtask

  initial begin
    bit got_done;
    int w0;
    n_cmp = 0; n_bad = 0; we_tot = 0; last_din = '0; rdata_model = '0;
    Clr = 1'b1; Req = 1'b0; Op = 3'b000; Addr = '0; Wdata = '0;
    repeat (2) @(negedge Clk);
    check_eq("rst_ready", 32'(Ready), 32'd1);
    check_eq("rst_done", 32'(Done), 32'd0);
    check_eq("rst_err", 32'(Err), 32'd0);
    check_eq("rst_rdata", Rdata, 32'd0);
    check_eq("rst_memaddr", MemAddr, 32'd0);
    check_eq("rst_memdin", MemDin, 32'd0);
    check_eq("rst_memwe", 32'(MemWe), 32'd0);
    Clr = 1'b0;

    do_op("sw10", 3'b101, 32'h10, 32'h12345678, 2, 1'b0, rdata_model, 1);
    rdata_model = 32'h12345678;
    do_op("lw10", 3'b000, 32'h10, 32'h0, 2, 1'b0, rdata_model, 0);

    do_op("sb11", 3'b111, 32'h11, 32'hFFFFFFAB, 3, 1'b0, rdata_model, 1);
    check_eq("sb11_memdin", last_din, 32'h1234AB78);
    rdata_model = 32'h1234AB78;
    do_op("lw10b", 3'b000, 32'h10, 32'h0, 2, 1'b0, rdata_model, 0);

    do_op("sw_h", 3'b101, 32'h10, 32'h8001FFFF, 2, 1'b0, rdata_model, 1);
    rdata_model = 32'hFFFF8001;
    do_op("lh12", 3'b001, 32'h12, 32'h0, 2, 1'b0, rdata_model, 0);
    rdata_model = 32'h00008001;
    do_op("lhu12", 3'b010, 32'h12, 32'h0, 2, 1'b0, rdata_model, 0);

    do_op("sw_b", 3'b101, 32'h10, 32'h80000000, 2, 1'b0, rdata_model, 1);
    rdata_model = 32'hFFFFFF80;
    do_op("lb13", 3'b011, 32'h13, 32'h0, 2, 1'b0, rdata_model, 0);
    rdata_model = 32'h00000080;
    do_op("lbu13", 3'b100, 32'h13, 32'h0, 2, 1'b0, rdata_model, 0);

    // Misaligned accesses: one-cycle error, no write, Rdata held.
    do_op("lw12_mis", 3'b000, 32'h12, 32'h0, 1, 1'b1, rdata_model, 0);
    do_op("sh11_mis", 3'b110, 32'h11, 32'hBEEF, 1, 1'b1, rdata_model, 0);

    // sh to upper half exercises the other half lane.
    do_op("sh12", 3'b110, 32'h12, 32'h0000CAFE, 3, 1'b0, rdata_model, 1);
    check_eq("sh12_memdin", last_din, 32'hCAFE0000);

    // Clr during WRITE must cancel the store.
    do_op("sw20_old", 3'b101, 32'h20, 32'h55AA55AA, 2, 1'b0, rdata_model, 1);
    @(negedge Clk);
    Req = 1'b1; Op = 3'b101; Addr = 32'h20; Wdata = 32'hDEADBEEF;
    @(posedge Clk);
    @(negedge Clk);
    Req = 1'b0;
    check_eq("clr_we_before", 32'(MemWe), 32'd1);
    w0 = we_tot;
    Clr = 1'b1;
    #1;
    check_eq("clr_we_after", 32'(MemWe), 32'd0);
    check_eq("clr_ready", 32'(Ready), 32'd1);
    check_eq("clr_done", 32'(Done), 32'd0);
    check_eq("clr_err", 32'(Err), 32'd0);
    check_eq("clr_rdata", Rdata, 32'd0);
    check_eq("clr_memaddr", MemAddr, 32'd0);
    check_eq("clr_memdin", MemDin, 32'd0);
    @(negedge Clk);
    Clr = 1'b0;
    got_done = 1'b0;
    repeat (4) begin
      @(negedge Clk);
      if (Done) got_done = 1'b1;
    end
    check_eq("clr_no_done", 32'(got_done), 32'd0);
    check_eq("clr_no_write", 32'(we_tot - w0), 32'd0);
    rdata_model = 32'h55AA55AA;
    do_op("lw20", 3'b000, 32'h20, 32'h0, 2, 1'b0, rdata_model, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
